// File: rtl/irq_arbiter_pkg.sv
// Shared definitions for the interrupt arbiter: FSM encoding, register map and status layout.
package irq_arbiter_pkg;

    localparam int unsigned ID_W   = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_PEND   = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_MASK   = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_MODE   = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 2'd3;

    typedef struct packed {
        logic [1:0]      state;
        logic [ID_W-1:0] id;
    } status_t;

endpackage

// File: rtl/irq_prio_sel.sv
// Combinational selector: first eligible source found scanning upward from start (or from 0 in fixed mode).
module irq_prio_sel
    import irq_arbiter_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0]    eligible,
    input  logic [ID_W-1:0] start,
    input  logic            mode,
    output logic [ID_W-1:0] winner,
    output logic            any
);

    logic [ID_W:0]   idx;
    logic [ID_W-1:0] base;
    logic [N-1:0]    shifted;
    logic            found;

    // Modular scan; idx is one bit wider so base + i never overflows before the wrap.
    always_comb begin
        winner  = '0;
        found   = 1'b0;
        idx     = '0;
        shifted = '0;
        base    = mode ? start : '0;
        for (int i = 0; i < N; i++) begin
            idx = (ID_W + 1)'(base) + (ID_W + 1)'(i);
            if (idx >= (ID_W + 1)'(N)) begin
                idx = idx - (ID_W + 1)'(N);
            end
            shifted = eligible >> idx;
            if (!found && shifted[0]) begin
                winner = idx[ID_W-1:0];
                found  = 1'b1;
            end
        end
        any = |eligible;
    end

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt arbiter: edge-latched pending bits, mask/mode registers, and a single-level REQ/SERVICE handshake to the CPU.
module irq_arbiter
    import irq_arbiter_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      irq_src,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_wdata,
    output logic [DATA_W-1:0] cfg_rdata,
    input  logic              inta,
    input  logic              eret,
    output logic              int_out,
    output logic [ID_W-1:0]   irq_id
);

    state_t          state;
    state_t          state_next;
    logic [N-1:0]    prev;
    logic [N-1:0]    pend;
    logic [N-1:0]    pend_next;
    logic [N-1:0]    mask;
    logic [N-1:0]    rise;
    logic [N-1:0]    w1c;
    logic [N-1:0]    eligible;
    logic [N-1:0]    id_onehot;
    logic            mode;
    logic [ID_W-1:0] last;
    logic [ID_W-1:0] rr_start;
    logic [ID_W-1:0] winner;
    logic            any;
    logic            cur_live;
    logic            int_next;
    logic            id_load;
    logic            ack;
    status_t         status;
    logic            unused_wdata;

    assign unused_wdata = ^cfg_wdata[DATA_W-1:N];

    assign rise      = irq_src & ~prev;
    assign eligible  = pend & mask;
    assign id_onehot = N'(1) << irq_id;
    assign cur_live  = |(eligible & id_onehot);
    assign rr_start  = (last == ID_W'(N - 1)) ? '0 : last + ID_W'(1);
    assign w1c       = (cfg_we && cfg_addr == ADDR_PEND) ? cfg_wdata[N-1:0] : '0;

    irq_prio_sel #(.N(N)) u_sel (
        .eligible (eligible),
        .start    (rr_start),
        .mode     (mode),
        .winner   (winner),
        .any      (any)
    );

    // Rises win over W1C; the acknowledge clear wins over everything for the granted bit.
    always_comb begin
        pend_next = (pend & ~w1c) | rise;
        if (ack) begin
            pend_next = pend_next & ~id_onehot;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // inta takes precedence over a same-cycle withdrawal.
    always_comb begin
        state_next = state;
        int_next   = 1'b0;
        id_load    = 1'b0;
        ack        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any) begin
                    state_next = ST_REQ;
                    int_next   = 1'b1;
                    id_load    = 1'b1;
                end
            end
            ST_REQ: begin
                if (inta) begin
                    state_next = ST_SERVICE;
                    ack        = 1'b1;
                end else if (!cur_live) begin
                    state_next = ST_IDLE;
                end else begin
                    int_next = 1'b1;
                end
            end
            ST_SERVICE: begin
                if (eret) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev    <= '0;
            pend    <= '0;
            mask    <= '0;
            mode    <= 1'b0;
            last    <= ID_W'(N - 1);
            irq_id  <= '0;
            int_out <= 1'b0;
        end else begin
            prev    <= irq_src;
            pend    <= pend_next;
            int_out <= int_next;
            if (cfg_we && cfg_addr == ADDR_MASK) begin
                mask <= cfg_wdata[N-1:0];
            end
            if (cfg_we && cfg_addr == ADDR_MODE) begin
                mode <= cfg_wdata[0];
            end
            if (id_load) begin
                irq_id <= winner;
            end
            if (ack) begin
                last <= irq_id;
            end
        end
    end

    always_comb begin
        status.state = state;
        status.id    = irq_id;
        case (cfg_addr)
            ADDR_PEND: cfg_rdata = DATA_W'(pend);
            ADDR_MASK: cfg_rdata = DATA_W'(mask);
            ADDR_MODE: cfg_rdata = DATA_W'(mode);
            default:   cfg_rdata = DATA_W'(status);
        endcase
    end

endmodule

// File: tb/tb_irq_arbiter.sv
// Bench for irq_arbiter: directed scenarios plus randomized traffic against a cycle-level behavioural model.
module tb_irq_arbiter;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] irq_src;
    logic         cfg_we;
    logic [1:0]   cfg_addr;
    logic [31:0]  cfg_wdata;
    logic [31:0]  cfg_rdata;
    logic         inta;
    logic         eret;
    logic         int_out;
    logic [3:0]   irq_id;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: 0 idle, 1 requesting, 2 in service.
    int           m_state;
    logic [N-1:0] m_pend, m_mask, m_prev;
    logic         m_mode;
    int           m_last, m_id;
    logic         m_int;

    irq_arbiter #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_src   (irq_src),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .inta      (inta),
        .eret      (eret),
        .int_out   (int_out),
        .irq_id    (irq_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] exp_read(input logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_pend);
            2'd1:    return 32'(m_mask);
            2'd2:    return 32'(m_mode);
            default: return {26'd0, 2'(m_state), 4'(m_id)};
        endcase
    endfunction

    function automatic int pick(input logic [N-1:0] el);
        int base;
        base = m_mode ? (m_last + 1) % N : 0;
        for (int k = 0; k < N; k++) begin
            if (el[(base + k) % N]) return (base + k) % N;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_state = 0; m_pend = '0; m_mask = '0; m_prev = '0; m_mode = 1'b0;
        m_last = N - 1; m_id = 0; m_int = 1'b0;
    endtask

    // Apply one cycle of inputs, advance both DUT and model, compare outputs.
    task automatic cyc(input logic [N-1:0] irq, input logic we, input logic [1:0] addr,
                       input logic [31:0] wd, input logic ia, input logic er);
        logic [N-1:0] np, nm, w1c;
        logic         nmode, nint;
        int           ns, nid, nlast;
        irq_src = irq; cfg_we = we; cfg_addr = addr; cfg_wdata = wd; inta = ia; eret = er;
        #1;
        check("rdata", cfg_rdata, exp_read(addr));
        w1c   = (we && addr == 2'd0) ? wd[N-1:0] : '0;
        np    = (m_pend & ~w1c) | (irq & ~m_prev);
        nm    = (we && addr == 2'd1) ? wd[N-1:0] : m_mask;
        nmode = (we && addr == 2'd2) ? wd[0] : m_mode;
        ns = m_state; nid = m_id; nlast = m_last; nint = 1'b0;
        case (m_state)
            0: if ((m_pend & m_mask) != '0) begin
                   ns = 1; nid = pick(m_pend & m_mask); nint = 1'b1;
               end
            1: if (ia) begin
                   ns = 2; np[m_id] = 1'b0; nlast = m_id;
               end else if (!(m_pend[m_id] && m_mask[m_id])) ns = 0;
               else nint = 1'b1;
            default: if (er) ns = 0;
        endcase
        @(posedge clk);
        m_prev = irq; m_pend = np; m_mask = nm; m_mode = nmode;
        m_state = ns; m_id = nid; m_last = nlast; m_int = nint;
        #1;
        check("int_out", 32'(int_out), 32'(m_int));
        check("irq_id", 32'(irq_id), 32'(m_id));
    endtask

    task automatic idle_cyc(input logic [N-1:0] irq);
        cyc(irq, 1'b0, 2'd3, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic peek(input string tag, input logic [1:0] a, input logic [31:0] exp);
        cfg_we = 1'b0; inta = 1'b0; eret = 1'b0; cfg_addr = a;
        #1;
        check(tag, cfg_rdata, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1; irq_src = '0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = '0;
        inta = 1'b0; eret = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        do_reset();
        check("rst_int_out", 32'(int_out), 32'd0);
        check("rst_irq_id", 32'(irq_id), 32'd0);
        peek("rst_mask", 2'd1, 32'd0);
        peek("rst_status", 2'd3, 32'd0);

        // Single source, two-edge latency, ack clears pend, eret returns to idle.
        cyc('0, 1'b1, 2'd1, 32'hFF, 1'b0, 1'b0);
        idle_cyc(8'h08);
        check("lat_k", 32'(int_out), 32'd0);
        idle_cyc(8'h00);
        check("lat_k1_int", 32'(int_out), 32'd1);
        check("lat_k1_id", 32'(irq_id), 32'd3);
        cyc('0, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0);
        peek("ack_pend", 2'd0, 32'd0);
        cyc('0, 1'b0, 2'd3, 32'd0, 1'b0, 1'b1);
        peek("eret_status", 2'd3, 32'h03);

        // Fixed priority: 2 before 5.
        do_reset();
        cyc('0, 1'b1, 2'd1, 32'hFF, 1'b0, 1'b0);
        idle_cyc(8'h24);
        idle_cyc(8'h00);
        check("fix_first", 32'(irq_id), 32'd2);
        cyc('0, 1'b0, 2'd3, 32'd0, 1'b1, 1'b0);
        cyc('0, 1'b0, 2'd3, 32'd0, 1'b0, 1'b1);
        idle_cyc(8'h00);
        check("fix_second", 32'(irq_id), 32'd5);

        // Round-robin order 0,1,2,0 with bit 0 re-raised during service of 1.
        do_reset();
        cyc('0, 1'b1, 2'd1, 32'hFF, 1'b0, 1'b0);
        cyc('0, 1'b1, 2'd2, 32'h1, 1'b0, 1'b0);
        idle_cyc(8'h07);
        idle_cyc(8'h00);
        check("rr_g0", 32'(irq_id), 32'd0);
        cyc('0, 1'b0, 2'd3, 32'd0, 1'b1, 1'b0);
        cyc('0, 1'b0, 2'd3, 32'd0, 1'b0, 1'b1);
        idle_cyc(8'h00);
        check("rr_g1", 32'(irq_id), 32'd1);
        cyc('0, 1'b0, 2'd3, 32'd0, 1'b1, 1'b0);
        idle_cyc(8'h01);
        cyc('0, 1'b0, 2'd3, 32'd0, 1'b0, 1'b1);
        idle_cyc(8'h00);
        check("rr_g2", 32'(irq_id), 32'd2);
        cyc('0, 1'b0, 2'd3, 32'd0, 1'b1, 1'b0);
        cyc('0, 1'b0, 2'd3, 32'd0, 1'b0, 1'b1);
        idle_cyc(8'h00);
        check("rr_g3", 32'(irq_id), 32'd0);

        // Withdrawal by masking the requesting source.
        do_reset();
        cyc('0, 1'b1, 2'd1, 32'hFF, 1'b0, 1'b0);
        idle_cyc(8'h10);
        idle_cyc(8'h00);
        check("wd_req_id", 32'(irq_id), 32'd4);
        cyc('0, 1'b1, 2'd1, 32'hEF, 1'b0, 1'b0);
        idle_cyc(8'h00);
        check("wd_int", 32'(int_out), 32'd0);
        peek("wd_status", 2'd3, 32'h04);
        peek("wd_pend", 2'd0, 32'h10);

        // Rise wins over same-cycle W1C; async reset from SERVICE.
        do_reset();
        cyc('0, 1'b1, 2'd1, 32'hFF, 1'b0, 1'b0);
        cyc(8'h40, 1'b1, 2'd0, 32'h40, 1'b0, 1'b0);
        peek("setclr_pend", 2'd0, 32'h40);
        idle_cyc(8'h00);
        check("setclr_id", 32'(irq_id), 32'd6);
        cyc('0, 1'b0, 2'd3, 32'd0, 1'b1, 1'b0);
        peek("svc_status", 2'd3, 32'h26);
        #2;
        rst = 1'b1;
        #1;
        check("arst_id", 32'(irq_id), 32'd0);
        check("arst_int", 32'(int_out), 32'd0);
        peek("arst_status", 2'd3, 32'd0);
        peek("arst_mask", 2'd1, 32'd0);
        peek("arst_pend", 2'd0, 32'd0);

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic        we;
            logic [31:0] wd;
            we = ($urandom_range(0, 7) == 0);
            wd = $urandom;
            if (we && $urandom_range(0, 3) == 0) wd = 32'(N'(1) << $urandom_range(0, N - 1));
            cyc(N'($urandom & $urandom), we, 2'($urandom_range(0, 3)), wd,
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
